// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand sequencer: default operand
// width, FSM state encodings and the flag derivation used at result capture.
package calc_pkg;

    // Default operand/result width, matching the 4-bit adder-subtractor.
    localparam int WIDTH_DEF = 4;

    // Encodings are visible on o_state and drive the display directly.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        SHOW   = 2'd3
    } state_e;

    // Adding reports carry-out; subtracting reports borrow, which is the
    // inverse of the adder's carry-out when it computes a + ~b + 1.
    function automatic logic calc_flag(input logic mode, input logic carry);
        return mode ? ~carry : carry;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Two-flop synchroniser for the asynchronous enter button followed by a
// rising-edge detector. o_pulse is high for one cycle after the synchronised
// level rises, so the consuming logic acts on the third edge that samples
// the button high. A held button yields a single pulse.
module btn_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign o_pulse = sync2_q & ~dly_q;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Operand sequencer for a two-operand calculator. Each enter press steps
// LOAD_A -> LOAD_B -> CALC -> SHOW -> LOAD_A, capturing operand A, then
// operand B with the mode, then registering the external adder-subtractor
// result. The adder itself lives outside this block.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_enter,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_sw_data,
    input  logic             i_sw_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_mode,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag,
    output logic             o_valid,
    output logic [1:0]       o_state
);

    logic enter_pulse;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             mode_q,   mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q,   flag_d;
    logic             valid_q,  valid_d;

    btn_edge_detect u_enter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_enter),
        .o_pulse (enter_pulse)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides any enter pulse, and CALC always
    // advances after one cycle regardless of the button.
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = LOAD_A;
        end else begin
            unique case (state_q)
                LOAD_A: if (enter_pulse) state_d = LOAD_B;
                LOAD_B: if (enter_pulse) state_d = CALC;
                CALC:   state_d = SHOW;
                SHOW:   if (enter_pulse) state_d = LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

    // Datapath next values: switches are sampled only on capture edges,
    // and everything holds otherwise so SHOW keeps its result on display.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        result_d = result_q;
        flag_d   = flag_q;
        valid_d  = 1'b0;
        if (i_clear) begin
            a_d      = '0;
            b_d      = '0;
            mode_d   = 1'b0;
            result_d = '0;
            flag_d   = 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (enter_pulse) begin
                        a_d = i_sw_data;
                    end
                end
                LOAD_B: begin
                    if (enter_pulse) begin
                        b_d    = i_sw_data;
                        mode_d = i_sw_mode;
                    end
                end
                CALC: begin
                    result_d = i_sum;
                    flag_d   = calc_flag(mode_q, i_carry);
                    valid_d  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers; reset discards any operation in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            valid_q  <= valid_d;
        end
    end

    assign o_a      = a_q;
    assign o_b      = b_q;
    assign o_mode   = mode_q;
    assign o_result = result_q;
    assign o_flag   = flag_q;
    assign o_valid  = valid_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a behavioural model of the
// external 4-bit adder-subtractor and a scoreboard of expected results.
module tb_calc_operand_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn;
    logic         clr;
    logic [W-1:0] sw;
    logic         sw_mode;
    logic [W-1:0] a, b, sum, result;
    logic         omode, carry, flag, valid;
    logic [1:0]   st;
    logic [W:0]   adder_full;

    typedef struct packed {
        logic [W-1:0] res;
        logic         flag;
    } exp_t;

    exp_t sb[$];
    int   tests      = 0;
    int   failed     = 0;
    int   valid_seen = 0;

    always #5 clk = ~clk;

    calc_operand_sequencer #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_enter (btn),
        .i_clear     (clr),
        .i_sw_data   (sw),
        .i_sw_mode   (sw_mode),
        .o_a         (a),
        .o_b         (b),
        .o_mode      (omode),
        .i_sum       (sum),
        .i_carry     (carry),
        .o_result    (result),
        .o_flag      (flag),
        .o_valid     (valid),
        .o_state     (st)
    );

    // External adder-subtractor: subtract as a + ~b + 1.
    always_comb begin
        if (omode) adder_full = {1'b0, a} + {1'b0, ~b} + 5'd1;
        else       adder_full = {1'b0, a} + {1'b0, b};
        sum   = adder_full[W-1:0];
        carry = adder_full[W];
    end

    always @(negedge clk) begin
        if (valid === 1'b1) valid_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise the button and return at the negedge after the capture edge.
    task automatic press();
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input logic m);
        exp_t       e;
        exp_t       got;
        logic [W:0] full;
        int         n;
        check("idle_state", st, 0);
        sw = opa;
        press();
        check("capA_state", st, 1);
        check("capA_value", a, opa);
        sw = ~opa;
        settle();
        check("A_holds", a, opa);
        sw      = opb;
        sw_mode = m;
        press();
        check("calc_state", st, 2);
        full  = {1'b0, opa} + {1'b0, opb};
        e.res = m ? (opa - opb) : full[W-1:0];
        e.flag = m ? (opa < opb) : full[W];
        sb.push_back(e);
        n = 0;
        while (valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("valid_pulse", valid, 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("result", result, got.res);
            check("flag", flag, got.flag);
        end
        check("show_state", st, 3);
        @(negedge clk);
        check("valid_one_cycle", valid, 0);
        check("show_hold", st, 3);
        settle();
        press();
        check("back_to_A", st, 0);
        check("result_kept", result, e.res);
        check("B_kept", b, opb);
        check("mode_kept", omode, m);
        settle();
    endtask

    initial begin
        rst_n   = 1'b0;
        btn     = 1'b0;
        clr     = 1'b0;
        sw      = '0;
        sw_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", st, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_mode", omode, 0);
        check("rst_result", result, 0);
        check("rst_flag", flag, 0);
        check("rst_valid", valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Button held for 20 cycles gives exactly one capture.
        sw  = 4'd6;
        btn = 1'b1;
        repeat (20) @(negedge clk);
        check("held_state", st, 1);
        check("held_a", a, 6);
        btn = 1'b0;
        settle();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clear_state", st, 0);
        check("clear_a", a, 0);

        run_op(4'd3, 4'd5, 1'b0);
        run_op(4'd9, 4'd8, 1'b0);
        run_op(4'd7, 4'd2, 1'b1);
        run_op(4'd2, 4'd7, 1'b1);

        // Clear in LOAD_B coinciding with an enter pulse.
        sw = 4'd5;
        press();
        settle();
        check("clrB_pre_state", st, 1);
        sw  = 4'd4;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clrB_state", st, 0);
        check("clrB_a", a, 0);
        check("clrB_b", b, 0);
        check("clrB_mode", omode, 0);
        check("clrB_result", result, 0);
        check("clrB_flag", flag, 0);
        check("clrB_valid", valid, 0);
        repeat (3) @(negedge clk);
        btn = 1'b0;
        settle();
        check("clrB_no_repulse", st, 0);

        run_op(4'd1, 4'd1, 1'b0);

        // Reset while in CALC drops the operation.
        sw = 4'd6;
        press();
        settle();
        sw = 4'd6;
        press();
        check("rstcalc_pre", st, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstcalc_state", st, 0);
        check("rstcalc_result", result, 0);
        check("rstcalc_flag", flag, 0);
        check("rstcalc_valid", valid, 0);

        // Button held through reset release yields one capture afterwards.
        btn = 1'b1;
        sw  = 4'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_rst_wait", st, 0);
        @(negedge clk);
        check("hold_rst_state", st, 1);
        check("hold_rst_a", a, 3);
        repeat (6) @(negedge clk);
        btn = 1'b0;
        settle();
        check("hold_rst_single", st, 1);
        check("valid_count", valid_seen, 5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
